// File: rtl/pes_tlc_sched_if.sv
// Signal bundle between the traffic-light scheduler and its environment.
// The master side drives the road/pedestrian requests, and the slave side
// (the scheduler) drives the lamps, the walk indication and the phase code.
interface pes_tlc_sched_if;
  logic       sensor;
  logic       ped_req;
  logic       emerg;
  logic [2:0] light_highway;
  logic [2:0] light_farm;
  logic       walk;
  logic [2:0] phase;

  modport master (
    output sensor, ped_req, emerg,
    input  light_highway, light_farm, walk, phase
  );

  modport slave (
    input  sensor, ped_req, emerg,
    output light_highway, light_farm, walk, phase
  );
endinterface

// File: rtl/pes_tlc_sched.sv
// Highway/farm-road traffic-light scheduler with pedestrian phase and
// emergency preempt. All lamp outputs decode from the registered state only.
// Each timed state lasts exactly its duration: the down-timer loads
// (duration-1) on entry, and the state exits on the cycle the timer reads 0.
module pes_tlc_sched #(
  parameter int MIN_GREEN  = 16,
  parameter int YEL        = 4,
  parameter int ALLRED     = 2,
  parameter int FARM_GREEN = 10,
  parameter int WALK       = 8
) (
  input  logic             clk,
  input  logic             rst,
  pes_tlc_sched_if.slave   bus
);

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    FG  = 3'd3,
    FY  = 3'd4,
    AR2 = 3'd5,
    PW  = 3'd6
  } state_t;

  localparam logic GNT_FARM = 1'b0;
  localparam logic GNT_PED  = 1'b1;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] timer;
  logic       ped_pend;
  logic       gnt;
  logic       last_srv;
  logic       gnt_sel;
  logic       entering;
  logic       timer_zero;

  // Timer load value for the state being entered.
  function automatic logic [7:0] load_val(input state_t s);
    case (s)
      HG:       load_val = 8'(MIN_GREEN - 1);
      HY, FY:   load_val = 8'(YEL - 1);
      AR1, AR2: load_val = 8'(ALLRED - 1);
      FG:       load_val = 8'(FARM_GREEN - 1);
      PW:       load_val = 8'(WALK - 1);
      default:  load_val = 8'(MIN_GREEN - 1);
    endcase
  endfunction

  assign timer_zero = (timer == 8'd0);
  assign entering   = (state_nxt != state);

  // Grant choice for the upcoming HG exit: a lone request wins outright, and
  // when both are pending the requester not served last time goes next.
  always_comb begin
    gnt_sel = GNT_FARM;
    if (bus.sensor && ped_pend)
      gnt_sel = ~last_srv;
    else if (ped_pend)
      gnt_sel = GNT_PED;
  end

  // Next-state selection; the preempt checks come before the timer checks so
  // that emerg wins when it coincides with timer expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      HG:  if (timer_zero && (bus.sensor || ped_pend) && !bus.emerg)
             state_nxt = HY;
      HY:  if (timer_zero) state_nxt = AR1;
      AR1: begin
        if (bus.emerg)
          state_nxt = HG;
        else if (timer_zero)
          state_nxt = (gnt == GNT_PED) ? PW : FG;
      end
      FG:  if (bus.emerg || timer_zero) state_nxt = FY;
      FY:  if (timer_zero) state_nxt = AR2;
      PW:  if (bus.emerg || timer_zero) state_nxt = AR2;
      AR2: if (timer_zero) state_nxt = HG;
      default: state_nxt = HG;
    endcase
  end

  // State register and down-timer; the timer reloads on every state change
  // and otherwise counts down, saturating at 0 (which only matters in HG).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HG;
      timer <= 8'(MIN_GREEN - 1);
    end else begin
      state <= state_nxt;
      if (entering)
        timer <= load_val(state_nxt);
      else if (!timer_zero)
        timer <= timer - 8'd1;
    end
  end

  // Request bookkeeping: pending pedestrian latch, grant register and the
  // record of which requester was served most recently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_pend <= 1'b0;
      gnt      <= GNT_FARM;
      last_srv <= GNT_PED;
    end else begin
      if (entering && state_nxt == PW)
        ped_pend <= 1'b0;
      else if (bus.ped_req)
        ped_pend <= 1'b1;

      if (state == HG && state_nxt == HY)
        gnt <= gnt_sel;

      if (entering && state_nxt == FG)
        last_srv <= GNT_FARM;
      else if (entering && state_nxt == PW)
        last_srv <= GNT_PED;
    end
  end

  // Lamp and walk decode from the registered state only.
  always_comb begin
    bus.light_highway = 3'b100;
    bus.light_farm    = 3'b100;
    bus.walk          = 1'b0;
    bus.phase         = 3'(state);
    case (state)
      HG:      bus.light_highway = 3'b001;
      HY:      bus.light_highway = 3'b010;
      FG:      bus.light_farm    = 3'b001;
      FY:      bus.light_farm    = 3'b010;
      PW:      bus.walk          = 1'b1;
      default: ;
    endcase
  end

endmodule
